// File: rtl/dsp_fe_gearbox_pkg.sv
// Shared types and elaboration helpers for the parametrised lane gearbox.
// The gearbox ratio R is the number of input beats that make up one output word.
package dsp_fe_gearbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAIL   = 2'd3
    } align_state_e;

    function automatic int unsigned gear_ratio(input int unsigned out_w, input int unsigned in_w);
        return out_w / in_w;
    endfunction

    function automatic bit gear_ratio_ok(input int unsigned out_w, input int unsigned in_w);
        return (in_w != 32'd0) && ((out_w % in_w) == 32'd0) && ((out_w / in_w) >= 32'd2);
    endfunction

endpackage

// File: rtl/dsp_fe_gearbox_acc.sv
// Per-channel beat accumulator: writes each accepted beat into its slot and
// captures the completed word (including the current beat) into the output register.
module dsp_fe_gearbox_acc #(
    parameter int DesInWidth  = 2,
    parameter int DesOutWidth = 4,
    parameter int CntWidth    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   load,
    input  logic [CntWidth-1:0]    slot,
    input  logic [DesInWidth-1:0]  din,
    output logic [DesOutWidth-1:0] word
);

    localparam int R = DesOutWidth / DesInWidth;

    logic [DesOutWidth-1:0] acc_r;
    logic [DesOutWidth-1:0] acc_next_s;
    logic [DesOutWidth-1:0] word_r;

    // Merge the incoming beat into the addressed slot.
    always_comb begin
        acc_next_s = acc_r;
        for (int i = 0; i < R; i++) begin
            if (int'(slot) == i) begin
                acc_next_s[i*DesInWidth +: DesInWidth] = din;
            end else begin
                acc_next_s[i*DesInWidth +: DesInWidth] = acc_r[i*DesInWidth +: DesInWidth];
            end
        end
    end

    // Slot storage and word register; both frozen while en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r  <= '0;
            word_r <= '0;
        end else if (en) begin
            acc_r <= acc_next_s;
            if (load) begin
                word_r <= acc_next_s;
            end
        end
    end

    assign word = word_r;

endmodule

// File: rtl/dsp_fe_lane_gearbox.sv
// Lane gearbox: gathers DesInWidth-sample beats into DesOutWidth-sample words,
// with manual beat slip and a training-pattern word-alignment FSM.
module dsp_fe_lane_gearbox
    import dsp_fe_gearbox_pkg::*;
#(
    parameter int AdcWidth     = 6,
    parameter int DesInWidth   = 2,
    parameter int DesOutWidth  = 4,
    parameter int AlignMatches = 4,
    parameter int ErrCntWidth  = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_en,
    input  logic [AdcWidth-1:0][DesInWidth-1:0]   i_dat,
    input  logic                                  i_slip,
    input  logic                                  i_align_start,
    input  logic [DesOutWidth-1:0]                i_align_pattern,
    output logic [AdcWidth-1:0][DesOutWidth-1:0]  o_dat,
    output logic                                  o_vld,
    output logic                                  o_locked,
    output logic                                  o_fail,
    output logic [$clog2(DesOutWidth/DesInWidth):0] o_slip_cnt,
    output logic [ErrCntWidth-1:0]                o_err_cnt
);

    localparam int R          = gear_ratio(DesOutWidth, DesInWidth);
    localparam int CntWidth   = (R > 1) ? $clog2(R) : 1;
    localparam int SlipWidth  = $clog2(R) + 1;
    localparam int MatchWidth = $clog2(AlignMatches + 1);

    if (!gear_ratio_ok(DesOutWidth, DesInWidth)) begin : g_bad_ratio
        $error("DesOutWidth must be a multiple (>=2) of DesInWidth");
    end
    if (AlignMatches < 1) begin : g_bad_matches
        $error("AlignMatches must be at least 1");
    end

    align_state_e          state_r, state_n;
    logic [CntWidth-1:0]   cnt_r;
    logic [MatchWidth-1:0] match_r, match_n;
    logic [SlipWidth-1:0]  slip_cnt_r, slip_cnt_n;
    logic [ErrCntWidth-1:0] err_cnt_r, err_cnt_n;
    logic                  discard_r, discard_n;
    logic                  pending_r, pending_n;
    logic                  vld_r, locked_r, fail_r;

    logic start_s, manual_slip_s, int_slip_s, slip_s, last_beat_s, load_s, word_match_s;

    // A restart on the same beat overrides any slip, manual or internal.
    assign start_s       = i_en & i_align_start;
    assign manual_slip_s = i_en & i_slip & (state_r != ST_SEARCH) & ~i_align_start;
    assign int_slip_s    = i_en & pending_r & ~i_align_start;
    assign slip_s        = manual_slip_s | int_slip_s;
    assign last_beat_s   = (cnt_r == CntWidth'(R - 1));
    assign load_s        = i_en & last_beat_s & ~slip_s;
    assign word_match_s  = (o_dat[AdcWidth-1] == i_align_pattern);

    for (genvar c = 0; c < AdcWidth; c++) begin : g_lane
        dsp_fe_gearbox_acc #(
            .DesInWidth (DesInWidth),
            .DesOutWidth(DesOutWidth),
            .CntWidth   (CntWidth)
        ) u_acc (
            .clk  (i_clk),
            .rst_n(i_rst_n),
            .en   (i_en),
            .load (load_s),
            .slot (cnt_r),
            .din  (i_dat[c]),
            .word (o_dat[c])
        );
    end

    // Beat slot counter and word strobe; a slipped beat leaves the counter in place.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
            vld_r <= 1'b0;
        end else begin
            vld_r <= load_s;
            if (i_en && !slip_s) begin
                cnt_r <= last_beat_s ? '0 : cnt_r + CntWidth'(1);
            end
        end
    end

    // Alignment next-state: acts on the word currently presented on o_dat.
    always_comb begin
        state_n    = state_r;
        match_n    = match_r;
        slip_cnt_n = slip_cnt_r;
        err_cnt_n  = err_cnt_r;
        discard_n  = discard_r;
        pending_n  = int_slip_s ? 1'b0 : pending_r;
        if (start_s) begin
            state_n    = ST_SEARCH;
            match_n    = '0;
            slip_cnt_n = '0;
            err_cnt_n  = '0;
            discard_n  = 1'b1;
            pending_n  = 1'b0;
        end else if (vld_r) begin
            case (state_r)
                ST_SEARCH: begin
                    if (discard_r) begin
                        discard_n = 1'b0;
                    end else if (word_match_s) begin
                        match_n = match_r + MatchWidth'(1);
                        if (match_r == MatchWidth'(AlignMatches - 1)) begin
                            state_n = ST_LOCKED;
                        end else begin
                            state_n = ST_SEARCH;
                        end
                    end else if (slip_cnt_r < SlipWidth'(R)) begin
                        pending_n  = 1'b1;
                        slip_cnt_n = slip_cnt_r + SlipWidth'(1);
                        match_n    = '0;
                        discard_n  = 1'b1;
                    end else begin
                        state_n = ST_FAIL;
                    end
                end
                ST_LOCKED: begin
                    if (!word_match_s && (err_cnt_r != {ErrCntWidth{1'b1}})) begin
                        err_cnt_n = err_cnt_r + ErrCntWidth'(1);
                    end else begin
                        err_cnt_n = err_cnt_r;
                    end
                end
                default: begin
                    state_n = state_r;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Alignment state, counters and registered status flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            match_r    <= '0;
            slip_cnt_r <= '0;
            err_cnt_r  <= '0;
            discard_r  <= 1'b0;
            pending_r  <= 1'b0;
            locked_r   <= 1'b0;
            fail_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            match_r    <= match_n;
            slip_cnt_r <= slip_cnt_n;
            err_cnt_r  <= err_cnt_n;
            discard_r  <= discard_n;
            pending_r  <= pending_n;
            locked_r   <= (state_n == ST_LOCKED);
            fail_r     <= (state_n == ST_FAIL);
        end
    end

    assign o_vld      = vld_r;
    assign o_locked   = locked_r;
    assign o_fail     = fail_r;
    assign o_slip_cnt = slip_cnt_r;
    assign o_err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_dsp_fe_lane_gearbox.sv
// Scoreboard bench for dsp_fe_lane_gearbox: a beat-list reference model predicts
// words and alignment status; a separate monitor checks every strobe.
module tb_dsp_fe_lane_gearbox;

    localparam int A  = 6;
    localparam int DI = 2;
    localparam int DO = 4;
    localparam int R  = DO / DI;
    localparam int AM = 4;
    localparam int EW = 8;
    localparam int SW = $clog2(R) + 1;
    localparam int DW = A * DI;

    localparam int M_IDLE = 0, M_SEARCH = 1, M_LOCKED = 2, M_FAIL = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   en = 1'b0;
    logic [A-1:0][DI-1:0]   dat = '0;
    logic                   slip = 1'b0;
    logic                   start = 1'b0;
    logic [DO-1:0]          cur_pat = '0;
    logic [A-1:0][DO-1:0]   o_dat;
    logic                   o_vld, o_locked, o_fail;
    logic [SW-1:0]          o_slip_cnt;
    logic [EW-1:0]          o_err_cnt;

    always #5 clk = ~clk;

    dsp_fe_lane_gearbox #(
        .AdcWidth(A), .DesInWidth(DI), .DesOutWidth(DO), .AlignMatches(AM), .ErrCntWidth(EW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dat(dat), .i_slip(slip),
        .i_align_start(start), .i_align_pattern(cur_pat),
        .o_dat(o_dat), .o_vld(o_vld), .o_locked(o_locked), .o_fail(o_fail),
        .o_slip_cnt(o_slip_cnt), .o_err_cnt(o_err_cnt)
    );

    typedef struct {
        logic [A-1:0][DO-1:0] w;
        int                   tag;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   k = 0;

    // Reference model: accepted beats queue up until R of them form a word.
    logic [A-1:0][DI-1:0] m_beats[$];
    logic                 m_vld;
    logic [A-1:0][DO-1:0] m_dat;
    int                   m_st, m_slips, m_match, m_err;
    bit                   m_discard, m_pending;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_beats.delete();
        m_vld = 1'b0; m_dat = '0;
        m_st = M_IDLE; m_slips = 0; m_match = 0; m_err = 0;
        m_discard = 1'b0; m_pending = 1'b0;
    endtask

    task automatic step(input bit r, input bit e, input bit s, input bit st, input logic [A-1:0][DI-1:0] d);
        bit                   st_ev, man, isl, nv;
        logic [A-1:0][DO-1:0] nw;
        rst_n = r; en = e; slip = s; start = st; dat = d;
        if (!r) begin
            model_reset();
        end else begin
            st_ev = e && st;
            man   = e && s && (m_st != M_SEARCH) && !st;
            isl   = e && m_pending && !st;
            nv    = 1'b0;
            nw    = m_dat;
            if (e && !(man || isl)) begin
                m_beats.push_back(d);
                if (m_beats.size() == R) begin
                    for (int i = 0; i < R; i++)
                        for (int c = 0; c < A; c++)
                            nw[c][i*DI +: DI] = m_beats[i][c];
                    nv = 1'b1;
                    m_beats.delete();
                    expq.push_back('{nw, cyc + 1});
                end
            end
            if (isl) m_pending = 1'b0;
            if (st_ev) begin
                m_st = M_SEARCH; m_slips = 0; m_match = 0; m_err = 0;
                m_discard = 1'b1; m_pending = 1'b0;
            end else if (m_vld) begin
                if (m_st == M_SEARCH) begin
                    if (m_discard) m_discard = 1'b0;
                    else if (m_dat[A-1] == cur_pat) begin
                        m_match++;
                        if (m_match == AM) m_st = M_LOCKED;
                    end else if (m_slips < R) begin
                        m_pending = 1'b1; m_slips++; m_match = 0; m_discard = 1'b1;
                    end else m_st = M_FAIL;
                end else if (m_st == M_LOCKED && m_dat[A-1] != cur_pat) begin
                    if (m_err < (1 << EW) - 1) m_err++;
                end
            end
            m_vld = nv;
            m_dat = nw;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [A-1:0][DI-1:0] rnd_beat();
        return DW'($urandom());
    endfunction

    // Random lanes with the training stream 0011 (two beats: 00 then 11) on the top channel.
    task automatic train_beat(input bit s, input bit st);
        logic [A-1:0][DI-1:0] d;
        d = rnd_beat();
        d[A-1] = k[0] ? 2'b11 : 2'b00;
        k++;
        step(1'b1, 1'b1, s, st, d);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_locked"}, o_locked, (m_st == M_LOCKED));
        check({tag, "_fail"}, o_fail, (m_st == M_FAIL));
        check({tag, "_slip_cnt"}, o_slip_cnt, m_slips);
        check({tag, "_err_cnt"}, o_err_cnt, m_err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dat"}, o_dat, 0);
        check({tag, "_vld"}, o_vld, 0);
        check({tag, "_locked"}, o_locked, 0);
        check({tag, "_fail"}, o_fail, 0);
        check({tag, "_slip_cnt"}, o_slip_cnt, 0);
        check({tag, "_err_cnt"}, o_err_cnt, 0);
    endtask

    // Monitor: every strobe must match the oldest predicted word due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (expq.size() > 0 && expq[0].tag < cyc) begin
                e = expq.pop_front();
                checks++; errors++;
                $display("FAIL vld_missing: no strobe for word %0h due at cycle %0d", e.w, e.tag);
            end
            if (o_vld) begin
                if (expq.size() == 0 || expq[0].tag != cyc) begin
                    checks++; errors++;
                    $display("FAIL vld_unexpected: o_vld=1 with o_dat=%0h at cycle %0d, no word due", o_dat, cyc);
                end else begin
                    e = expq.pop_front();
                    check("word", o_dat, e.w);
                end
            end else if (expq.size() > 0 && expq[0].tag == cyc) begin
                e = expq.pop_front();
                checks++; errors++;
                $display("FAIL vld_missing: o_vld=0 at cycle %0d, expected word %0h", cyc, e.w);
            end
        end
    end

    initial begin
        logic [A-1:0][DI-1:0] d;
        model_reset();

        // Reset with random data, then the basic two-beat word.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rnd_beat());
        check_zero("reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, {A{2'b01}});
        check("first_beat_vld", o_vld, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, {A{2'b10}});
        check("basic_vld", o_vld, 1);
        check("basic_word", o_dat[0], 4'b1001);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, rnd_beat());

        // Enable gap between the two halves of a word.
        step(1'b1, 1'b1, 1'b0, 1'b0, rnd_beat());
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1), rnd_beat());
        step(1'b1, 1'b1, 1'b0, 1'b0, rnd_beat());
        check_status("en_gap");

        // Manual slip on beat 1 of a channel-encoded stream (prefix beat completes the open word).
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 1'b0, rnd_beat());
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < A; c++) d[c] = DI'(b + c);
            step(1'b1, 1'b1, (b == 1), 1'b0, d);
            if (b == 3) check("slip_word_32", o_dat[0], 4'b1110);
        end
        check("slip_cnt_manual", o_slip_cnt, 0);

        // Randomised datapath traffic with gaps and slips in IDLE.
        for (int i = 0; i < 200; i++)
            step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 1'b0, rnd_beat());
        check_status("random");

        // Auto-align on a one-beat-offset training stream; slip with start is ignored.
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        k = 0;
        cur_pat = 4'b0011;
        train_beat(1'b1, 1'b1);
        for (int i = 0; i < 29; i++) train_beat(1'b0, 1'b0);
        check("align_locked", o_locked, 1);
        check("align_slip_cnt", o_slip_cnt, 1);
        check_status("align");

        // Unreachable pattern: two slips, one more mismatch, then FAIL.
        cur_pat = 4'b0101;
        train_beat(1'b0, 1'b1);
        for (int i = 0; i < 39; i++) train_beat((i == 4), 1'b0);
        check("fail_flag", o_fail, 1);
        check("fail_slip_cnt", o_slip_cnt, 2);
        check_status("fail");
        train_beat(1'b0, 1'b1);
        check("restart_fail", o_fail, 0);
        check("restart_slip_cnt", o_slip_cnt, 0);
        check_status("restart");

        // Relock, then flood with mismatching words until the error counter saturates.
        cur_pat = 4'b0011;
        train_beat(1'b0, 1'b1);
        for (int i = 0; i < 39; i++) train_beat((i == 3), 1'b0);
        check("relock", o_locked, 1);
        for (int i = 0; i < 600; i++) begin
            d = rnd_beat();
            d[A-1] = 2'b11;
            step(1'b1, 1'b1, 1'b0, 1'b0, d);
        end
        check("err_saturated", o_err_cnt, 255);
        check_status("locked_err");

        // Reset in the middle of a word.
        step(1'b1, 1'b1, 1'b0, 1'b0, rnd_beat());
        step(1'b0, 1'b1, 1'b0, 1'b0, rnd_beat());
        check_zero("midword_reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, {A{2'b11}});
        step(1'b1, 1'b1, 1'b0, 1'b0, {A{2'b00}});
        check("post_reset_word", o_dat[A-1], 4'b0011);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("queue_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
